// File: rtl/hilo_muldiv_unit.sv
// HI/LO register file with single-cycle multiply/MAC and
// iterative restoring divider for the EX stage.
module hilo_muldiv_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              cancel,
  output logic              op_ready,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam int PW    = 2 * DATA_W;

  localparam logic [2:0] OP_MTHI  = 3'b000;
  localparam logic [2:0] OP_MTLO  = 3'b001;
  localparam logic [2:0] OP_MULT  = 3'b010;
  localparam logic [2:0] OP_MULTU = 3'b011;
  localparam logic [2:0] OP_DIV   = 3'b100;
  localparam logic [2:0] OP_DIVU  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] dvs_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              neg_q_q;
  logic              neg_r_q;
  logic              dz_q;
  logic              done_q;
  logic              dbz_q;

  logic              accept;
  logic              is_div;
  logic              sgn;
  logic [DATA_W-1:0] a_abs;
  logic [DATA_W-1:0] b_abs;
  logic [PW-1:0]     sa_ext;
  logic [PW-1:0]     sb_ext;
  logic [PW-1:0]     prod_s;
  logic [PW-1:0]     prod_u;
  logic [PW-1:0]     hilo;
  logic [PW-1:0]     mac_add;
  logic [PW-1:0]     mac_sub;
  logic [DATA_W:0]   shl;
  logic [DATA_W:0]   diff;
  logic              fits;
  logic [DATA_W-1:0] rem_nx;
  logic [DATA_W-1:0] quo_nx;
  logic [DATA_W-1:0] q_fix;
  logic [DATA_W-1:0] r_fix;

  assign op_ready    = (state_q == IDLE);
  assign busy        = ~op_ready;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;

  assign accept = op_valid & op_ready & ~cancel;
  assign is_div = (op[2:1] == 2'b10);
  assign sgn    = (op == OP_DIV);

  // Magnitudes fed to the unsigned divider core
  assign a_abs = (sgn && src_a[DATA_W-1]) ? -src_a : src_a;
  assign b_abs = (sgn && src_b[DATA_W-1]) ? -src_b : src_b;

  // Full-width products; sign-extended operands give the signed product mod 2^PW
  assign sa_ext  = {{DATA_W{src_a[DATA_W-1]}}, src_a};
  assign sb_ext  = {{DATA_W{src_b[DATA_W-1]}}, src_b};
  assign prod_s  = sa_ext * sb_ext;
  assign prod_u  = {{DATA_W{1'b0}}, src_a} * {{DATA_W{1'b0}}, src_b};
  assign hilo    = {hi_q, lo_q};
  assign mac_add = hilo + prod_s;
  assign mac_sub = hilo - prod_s;

  // One restoring step: dividend bits shift out of quo into rem
  assign shl    = {rem_q, quo_q[DATA_W-1]};
  assign diff   = shl - {1'b0, dvs_q};
  assign fits   = ~diff[DATA_W];
  assign rem_nx = fits ? diff[DATA_W-1:0] : shl[DATA_W-1:0];
  assign quo_nx = {quo_q[DATA_W-2:0], fits};

  assign q_fix = neg_q_q ? -quo_q : quo_q;
  assign r_fix = neg_r_q ? -rem_q : rem_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; cancel aborts RUN/FIX
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept && is_div) state_d = RUN;
      RUN: begin
        if (cancel)                      state_d = IDLE;
        else if (cnt_q == CNT_W'(1))     state_d = FIX;
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // HI/LO, divider datapath and result flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q    <= '0;
      lo_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            done_q <= ~is_div;
            unique case (op)
              OP_MTHI:  hi_q <= src_a;
              OP_MTLO:  lo_q <= src_a;
              OP_MULT:  {hi_q, lo_q} <= prod_s;
              OP_MULTU: {hi_q, lo_q} <= prod_u;
              OP_MADD:  {hi_q, lo_q} <= mac_add;
              OP_MSUB:  {hi_q, lo_q} <= mac_sub;
              OP_DIV, OP_DIVU: begin
                quo_q   <= a_abs;
                rem_q   <= '0;
                dvs_q   <= b_abs;
                neg_q_q <= sgn & (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
                neg_r_q <= sgn & src_a[DATA_W-1];
                dz_q    <= (src_b == '0);
                cnt_q   <= CNT_W'(DATA_W);
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cancel) begin
            cnt_q <= '0;
          end else begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        FIX: begin
          cnt_q <= '0;
          if (!cancel) begin
            if (!dz_q) begin
              lo_q <= q_fix;
              hi_q <= r_fix;
            end
            done_q <= 1'b1;
            dbz_q  <= dz_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: driver pushes expected
// HI/LO results, a monitor pops them on every done pulse.
module tb_hilo_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         op_valid = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         cancel = 1'b0;
  logic         op_ready;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  hilo_muldiv_unit #(.DATA_W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .op_valid    (op_valid),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .cancel      (cancel),
    .op_ready    (op_ready),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi_o        (hi_o),
    .lo_o        (lo_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: compare each done pulse against the oldest expectation
  always @(negedge clk) begin
    if (rst) begin
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual hi=%h lo=%h required none",
                   hi_o, lo_o);
        end else begin
          e = sb.pop_front();
          chk("hi", 64'(hi_o), 64'(e.hi));
          chk("lo", 64'(lo_o), 64'(e.lo));
          chk("dbz", 64'(div_by_zero), 64'(e.dbz));
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
        end
      end else begin
        chk("dbz_idle", 64'(div_by_zero), 64'(0));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!op_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!op_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
  endtask

  // Issue one op; optionally record its expected result and done cycle
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic push,
                       input logic [W-1:0] xh, input logic [W-1:0] xl,
                       input logic xz);
    exp_t x;
    int   lat;
    wait_ready();
    lat = (o[2:1] == 2'b10) ? W + 1 : 0;
    op_valid = 1'b1;
    op = o;
    src_a = a;
    src_b = b;
    if (push) begin
      x.hi = xh;
      x.lo = xl;
      x.dbz = xz;
      x.cyc = cyc + 1 + lat;
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask

  initial begin
    int bad;
    int n;
    #2 rst = 1'b0;
    #10;
    chk("rst_hi", 64'(hi_o), 64'(0));
    chk("rst_lo", 64'(lo_o), 64'(0));
    chk("rst_ready", 64'(op_ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Moves, back to back
    issue(3'b000, 32'h12345678, 0, 1, 32'h12345678, 32'h0, 0);
    issue(3'b001, 32'h9ABCDEF0, 0, 1, 32'h12345678, 32'h9ABCDEF0, 0);
    chk("mt_ready", 64'(op_ready), 64'(1));

    // Multiplies
    issue(3'b010, 32'hFFFFFFFF, 32'h2, 1, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
    issue(3'b011, 32'hFFFFFFFF, 32'h2, 1, 32'h00000001, 32'hFFFFFFFE, 0);
    issue(3'b010, 32'hFFFFFFFD, 32'hFFFFFFFB, 1, 32'h0, 32'hF, 0);
    issue(3'b110, 32'hFFFFFFFF, 32'h3, 1, 32'h0, 32'hC, 0);

    // MADD/MSUB wrap
    issue(3'b000, 32'hFFFFFFFF, 0, 1, 32'hFFFFFFFF, 32'hC, 0);
    issue(3'b001, 32'hFFFFFFFF, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    issue(3'b110, 32'h1, 32'h1, 1, 32'h0, 32'h0, 0);
    issue(3'b111, 32'h1, 32'h1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);

    // Signed divide -7/2 with busy tracked across the full latency
    issue(3'b100, 32'hFFFFFFF9, 32'h2, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    bad = 0;
    for (int i = 0; i <= W; i++) begin
      if (busy !== 1'b1 || op_ready !== 1'b0) bad++;
      @(posedge clk);
      #1;
    end
    chk("div_busy_cycles_bad", 64'(bad), 64'(0));
    chk("div_ready_after", 64'(op_ready), 64'(1));

    issue(3'b100, 32'h80000000, 32'hFFFFFFFF, 1, 32'h0, 32'h80000000, 0);
    issue(3'b100, 32'h7, 32'hFFFFFFFE, 1, 32'h1, 32'hFFFFFFFD, 0);
    issue(3'b101, 32'd100, 32'd7, 1, 32'd2, 32'd14, 0);

    // Divide by zero leaves HI/LO alone
    issue(3'b000, 32'hA, 0, 1, 32'hA, 32'd14, 0);
    issue(3'b001, 32'hB, 0, 1, 32'hA, 32'hB, 0);
    issue(3'b101, 32'd5, 32'd0, 1, 32'hA, 32'hB, 1);

    // Cancel at divide cycle 10
    issue(3'b100, 32'd100, 32'd7, 0, 0, 0, 0);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    cancel = 1'b1;
    @(posedge clk);
    #1 cancel = 1'b0;
    chk("cancel_ready", 64'(op_ready), 64'(1));
    repeat (40) begin
      @(posedge clk);
      #1;
    end
    chk("cancel_hi", 64'(hi_o), 64'(32'hA));
    chk("cancel_lo", 64'(lo_o), 64'(32'hB));

    // Cancel in IDLE blocks acceptance
    op_valid = 1'b1;
    op = 3'b000;
    src_a = 32'h55;
    cancel = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    cancel = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_cancel_hi", 64'(hi_o), 64'(32'hA));

    issue(3'b011, 32'd3, 32'd4, 1, 32'h0, 32'hC, 0);
    issue(3'b000, 32'h7, 0, 1, 32'h7, 32'hC, 0);

    // Async reset mid-divide
    issue(3'b101, 32'd100, 32'd7, 0, 0, 0, 0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    chk("arst_hi", 64'(hi_o), 64'(0));
    chk("arst_lo", 64'(lo_o), 64'(0));
    chk("arst_ready", 64'(op_ready), 64'(1));
    chk("arst_busy", 64'(busy), 64'(0));
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    issue(3'b001, 32'h1, 0, 1, 32'h0, 32'h1, 0);

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (3) @(posedge clk);
    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
Parametrised HI/LO register file with an integrated multiply/divide engine for the EX stage of the MIPS-style pipeline. It accepts one HI/LO operation per handshake: direct move (MTHI/MTLO), single-cycle multiply, multiply-accumulate/subtract, or iterative radix-2 divide. It holds HI/LO architecturally and reports busy/done so the pipeline can stall on divides and flush them on exceptions.

Parameters:
DATA_W, 32, width of HI, LO and operands; product/accumulator is 2*DATA_W.
CNT_W, $clog2(DATA_W)+1, divide iteration counter width (derived, not overridden).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous reset, active-low (0 = reset).
op_valid  input  1  operation request.
op  input  3  000 MTHI, 001 MTLO, 010 MULT, 011 MULTU, 100 DIV, 101 DIVU, 110 MADD, 111 MSUB.
src_a  input  DATA_W  rs operand (dividend / multiplicand / move data).
src_b  input  DATA_W  rt operand (divisor / multiplier).
cancel  input  1  pipeline flush; aborts any in-flight divide.
op_ready  output  1  high when an op can be accepted (state IDLE).
busy  output  1  equals ~op_ready.
done  output  1  one-cycle pulse: the HI/LO result of an accepted op is visible.
div_by_zero  output  1  valid with done; set when a DIV/DIVU had src_b==0.
hi_o  output  DATA_W  current HI.
lo_o  output  DATA_W  current LO.

Behaviour:
- Reset (rst=0, async): hi_o=0, lo_o=0, state=IDLE, done=0, div_by_zero=0, counter=0, op_ready=1.
- Accept: op_valid & op_ready & ~cancel at a rising edge (edge E0). Otherwise the request is ignored and no state changes.
- MTHI/MTLO: at E0 write src_a to HI (MTHI) or LO (MTLO); the other register is unchanged. done=1 for the cycle after E0.
- MULT/MULTU: at E0 {HI,LO} <= signed/unsigned src_a*src_b (full 2*DATA_W). done the cycle after E0.
- MADD/MSUB: at E0 {HI,LO} <= {HI,LO} ± signed(src_a*src_b), wrapping mod 2^(2*DATA_W). done the cycle after E0.
- DIV/DIVU: states IDLE -> RUN -> FIX -> IDLE.
  - At E0 latch |a|, |b| (signed) or raw values (unsigned), plus the sign flags; enter RUN with counter=DATA_W.
  - Each RUN edge performs one restoring shift-subtract step and decrements the counter. RUN lasts DATA_W edges (E1..E_DATA_W).
  - FIX at edge E_(DATA_W+1): apply signs, write LO=quotient and HI=remainder, return to IDLE. done=1 in the following cycle.
  - Total: HI/LO update DATA_W+1 edges after acceptance; op_ready is low from E0 until FIX completes.
- Signed divide semantics:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Most-negative / -1 gives LO=most-negative (wrap), HI=0.
- Divide by zero: runs full latency; HI/LO unchanged; done=1 and div_by_zero=1 together for one cycle.
- div_by_zero is 0 whenever done is 0 and for every non-divide op.
- cancel:
  - In RUN/FIX, return to IDLE at the next edge; HI/LO unchanged; no done.
  - In IDLE, it blocks acceptance.
  - Single-cycle ops already written at E0 are not undone.
- Back-to-back: in IDLE a new op may be accepted every cycle; done pulses accordingly, one per op.
- hi_o/lo_o are registered; no bypass of the same-cycle write.
- Asynchronous reset mid-divide: immediate return to reset values; the partial result is discarded.

Test Plan:
- Reset then MTHI 0x12345678, next cycle MTLO 0x9ABCDEF0 -> hi_o=0x12345678, lo_o=0x9ABCDEF0; two done pulses; op_ready stays 1.
- MULT 0xFFFFFFFF*0x00000002 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE. done one cycle after each accept.
- Preload HI=LO=0xFFFFFFFF, then MADD 1*1 -> HI=0, LO=0 (wrap). MSUB 1*1 from 0 -> HI=LO=0xFFFFFFFF.
- DIV -7/2 (0xFFFFFFF9, 2) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; done exactly 34 cycles after accept (DATA_W=32); busy=1 throughout. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU 100/7 -> LO=14, HI=2.
- DIVU 5/0 with HI=0xA, LO=0xB -> done with div_by_zero=1; HI=0xA, LO=0xB unchanged.
- Cancel during DIV cycle 10 -> op_ready=1 next cycle, no done, HI/LO unchanged. Drop rst to 0 mid-divide -> outputs 0 immediately, op_ready=1.
